// File: rtl/char_ram_arbiter_if.sv
// Shared-port bundle between the VGA fetcher, the CPU bus and the character RAM.
// The master modport is the requester/RAM side and the slave modport is the arbiter.
interface char_ram_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  vga_gnt, vga_rvalid, vga_rdata, cpu_gnt, cpu_rvalid, cpu_rdata,
               ram_addr, ram_we, ram_wdata
    );

    modport slave (
        input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output vga_gnt, vga_rvalid, vga_rdata, cpu_gnt, cpu_rvalid, cpu_rdata,
               ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/char_ram_arbiter.sv
// Character RAM port arbiter: VGA priority with a bounded run so the CPU is never starved,
// registered RAM command and a two-stage tag pipe that routes read data back to its owner.
module char_ram_arbiter #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 8,
    parameter int MAX_VGA_RUN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    char_ram_arbiter_if.slave    bus
);
    localparam int               RUN_W   = $clog2(MAX_VGA_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_VGA_RUN);

    logic [RUN_W-1:0]  r_run_cnt;
    logic              w_vga_gnt;
    logic              w_cpu_gnt;

    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_we;
    logic [DATA_W-1:0] r_ram_wdata;

    logic              r_s1_valid, r_s1_vga, r_s1_rd;
    logic              r_s2_valid, r_s2_vga, r_s2_rd;
    logic              w_vga_rv, w_cpu_rv;
    logic [DATA_W-1:0] r_vga_rdata, r_cpu_rdata;

    // Grants are gated by rst_n so nothing is issued while reset is held.
    always_comb begin
        w_vga_gnt = rst_n & bus.vga_req & (~bus.cpu_req | (r_run_cnt != RUN_MAX));
        w_cpu_gnt = rst_n & bus.cpu_req & ~w_vga_gnt;
    end

    assign bus.vga_gnt = w_vga_gnt;
    assign bus.cpu_gnt = w_cpu_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_cnt <= '0;
        end else if (!bus.cpu_req || w_cpu_gnt) begin
            r_run_cnt <= '0;
        end else if (w_vga_gnt && (r_run_cnt != RUN_MAX)) begin
            r_run_cnt <= r_run_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
        end else if (w_vga_gnt) begin
            r_ram_addr  <= bus.vga_addr;
            r_ram_we    <= 1'b0;
        end else if (w_cpu_gnt) begin
            r_ram_addr  <= bus.cpu_addr;
            r_ram_we    <= bus.cpu_we;
            r_ram_wdata <= bus.cpu_wdata;
        end else begin
            r_ram_we    <= 1'b0;
        end
    end

    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_wdata = r_ram_wdata;

    // Stage 1 travels with the RAM command, stage 2 lines up with ram_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_vga   <= 1'b0;
            r_s1_rd    <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_vga   <= 1'b0;
            r_s2_rd    <= 1'b0;
        end else begin
            r_s1_valid <= w_vga_gnt | w_cpu_gnt;
            r_s1_vga   <= w_vga_gnt;
            r_s1_rd    <= w_vga_gnt | (w_cpu_gnt & ~bus.cpu_we);
            r_s2_valid <= r_s1_valid;
            r_s2_vga   <= r_s1_vga;
            r_s2_rd    <= r_s1_rd;
        end
    end

    assign w_vga_rv = r_s2_valid & r_s2_vga & r_s2_rd;
    assign w_cpu_rv = r_s2_valid & ~r_s2_vga & r_s2_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vga_rdata <= '0;
            r_cpu_rdata <= '0;
        end else begin
            if (w_vga_rv) r_vga_rdata <= bus.ram_rdata;
            if (w_cpu_rv) r_cpu_rdata <= bus.ram_rdata;
        end
    end

    // RAM data is forwarded in the stage-2 cycle and held afterwards, giving two-cycle latency.
    assign bus.vga_rvalid = w_vga_rv;
    assign bus.cpu_rvalid = w_cpu_rv;
    assign bus.vga_rdata  = w_vga_rv ? bus.ram_rdata : r_vga_rdata;
    assign bus.cpu_rdata  = w_cpu_rv ? bus.ram_rdata : r_cpu_rdata;
endmodule

// File: tb/tb_char_ram_arbiter.sv
// Randomized bench for char_ram_arbiter with a synchronous-read RAM model and a
// transaction-level reference (grant rule, shadow memory, per-grant expected reads).
module tb_char_ram_arbiter;
    localparam int AW   = 11;
    localparam int DW   = 8;
    localparam int MAXR = 4;
    localparam int NMEM = 2048;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    char_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    char_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_VGA_RUN(MAXR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned ram_seed;
    logic [DW-1:0] ram_mem [NMEM];
    logic [DW-1:0] ref_mem [NMEM];
    logic mem_ready = 1'b0;

    function automatic logic [DW-1:0] init_byte(int i);
        if (i == 5) return 8'h41;
        return 8'((i * 97) ^ int'(ram_seed));
    endfunction

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < NMEM; i++) ram_mem[i] <= init_byte(i);
            mem_ready <= 1'b1;
        end else if (bus.ram_we) begin
            ram_mem[bus.ram_addr] <= bus.ram_wdata;
        end
        bus.ram_rdata <= ram_mem[bus.ram_addr];
    end

    typedef struct packed {
        logic          v;
        logic          vga;
        logic          rd;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    typedef struct packed {
        logic          vg;
        logic          cg;
        logic          vrv;
        logic [DW-1:0] vrd;
        logic          crv;
        logic [DW-1:0] crd;
        logic [AW-1:0] ra;
        logic          rwe;
    } snap_t;

    // Reference: grants from the priority/run rule, each grant becomes an entry that
    // surfaces as a read result two cycles later; writes land in ref_mem one cycle after grant.
    ent_t          p0, p1;
    int            run;
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [DW-1:0] last_v, last_c;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic model_reset();
        p0 = '0; p1 = '0; run = 0;
        m_addr = '0; m_we = 1'b0; last_v = '0; last_c = '0;
    endtask

    task automatic cyc(input logic vr, input logic [AW-1:0] va, input logic cr, input logic cw,
                       input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       output snap_t o, output snap_t e);
        ent_t n;
        bus.vga_req = vr; bus.vga_addr = va;
        bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
        @(negedge clk);
        e.vg  = vr && (!cr || run != MAXR);
        e.cg  = cr && !e.vg;
        e.vrv = p1.v && p1.vga && p1.rd;
        e.vrd = e.vrv ? p1.d : last_v;
        e.crv = p1.v && !p1.vga && p1.rd;
        e.crd = e.crv ? p1.d : last_c;
        e.ra  = m_addr;
        e.rwe = m_we;
        o.vg  = bus.vga_gnt;    o.cg  = bus.cpu_gnt;
        o.vrv = bus.vga_rvalid; o.vrd = bus.vga_rdata;
        o.crv = bus.cpu_rvalid; o.crd = bus.cpu_rdata;
        o.ra  = bus.ram_addr;   o.rwe = bus.ram_we;
        @(posedge clk);
        if (e.vrv) last_v = p1.d;
        if (e.crv) last_c = p1.d;
        if (p0.v && !p0.rd) ref_mem[p0.a] = p0.d;
        p1 = p0;
        n = '0;
        if (e.vg) begin
            n.v = 1'b1; n.vga = 1'b1; n.rd = 1'b1; n.a = va; n.d = ref_mem[va];
        end else if (e.cg) begin
            n.v = 1'b1; n.rd = !cw; n.a = ca; n.d = cw ? cd : ref_mem[ca];
        end
        p0 = n;
        if (e.vg || e.cg) m_addr = n.a;
        m_we = e.cg && cw;
        if (!cr || e.cg) run = 0;
        else if (e.vg) run = (run < MAXR) ? run + 1 : MAXR;
        #1;
    endtask

    task automatic test_reset();
        snap_t o;
        bus.vga_req = 1'b1; bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
        @(negedge clk);
        o.vg  = bus.vga_gnt;    o.cg  = bus.cpu_gnt;
        o.vrv = bus.vga_rvalid; o.vrd = bus.vga_rdata;
        o.crv = bus.cpu_rvalid; o.crd = bus.cpu_rdata;
        o.ra  = bus.ram_addr;   o.rwe = bus.ram_we;
        n_cmp++;
        if (o !== snap_t'(0)) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected 0", o);
        end
        n_cmp++;
        if (bus.ram_wdata !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_wdata: got %h expected 00", bus.ram_wdata);
        end
        bus.vga_req = 1'b0; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_vga();
        snap_t o, e;
        for (int i = 0; i < 4; i++) begin
            cyc(i == 0, 11'h005, 1'b0, 1'b0, '0, '0, o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL single_vga cyc %0d: got %h expected %h", i, o, e);
            end
            if (i == 1) begin
                n_cmp++;
                if (o.ra !== 11'h005) begin
                    n_bad++;
                    $display("FAIL single_vga_addr: got %h expected 005", o.ra);
                end
            end
            if (i == 2) begin
                n_cmp++;
                if (o.vrv !== 1'b1 || o.vrd !== 8'h41 || o.crv !== 1'b0) begin
                    n_bad++;
                    $display("FAIL single_vga_data: got rv=%b d=%h crv=%b expected 1 41 0", o.vrv, o.vrd, o.crv);
                end
            end
        end
    endtask

    task automatic test_write_read();
        snap_t o, e;
        int we_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, '0, i < 2, i == 0, 11'h010, 8'h5A, o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL write_read cyc %0d: got %h expected %h", i, o, e);
            end
            if (o.rwe) we_pulses++;
            if (i == 3) begin
                n_cmp++;
                if (o.crv !== 1'b1 || o.crd !== 8'h5A) begin
                    n_bad++;
                    $display("FAIL write_read_data: got rv=%b d=%h expected 1 5a", o.crv, o.crd);
                end
            end
        end
        n_cmp++;
        if (we_pulses != 1) begin
            n_bad++;
            $display("FAIL write_read_we_pulses: got %0d expected 1", we_pulses);
        end
    endtask

    task automatic test_contention();
        snap_t o, e;
        for (int i = 0; i < 22; i++) begin
            cyc(i < 20, AW'($urandom), i < 20, 1'b0, AW'($urandom), '0, o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL contention cyc %0d: got %h expected %h", i, o, e);
            end
            if (i < 20) begin
                n_cmp++;
                if (o.cg !== ((i % 5) == 4) || o.vg !== ((i % 5) != 4)) begin
                    n_bad++;
                    $display("FAIL contention_pattern cyc %0d: got vg=%b cg=%b", i, o.vg, o.cg);
                end
            end
        end
    endtask

    task automatic test_stream();
        snap_t o, e;
        int gnts = 0, rvs = 0;
        for (int i = 0; i < 123; i++) begin
            cyc(i < 121, AW'(i), 1'b0, 1'b0, '0, '0, o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL stream cyc %0d: got %h expected %h", i, o, e);
            end
            if (o.vg) gnts++;
            if (o.vrv) rvs++;
        end
        n_cmp++;
        if (gnts != 121 || rvs != 121) begin
            n_bad++;
            $display("FAIL stream_counts: got gnt=%0d rvalid=%0d expected 121 121", gnts, rvs);
        end
    endtask

    task automatic test_cpu_7ff();
        snap_t o, e;
        logic [DW-1:0] wq[$];
        logic [DW-1:0] d = '0;
        logic [DW-1:0] want;
        int reads = 0;
        for (int i = 0; i < 18; i++) begin
            if (i % 2 == 0) d = DW'($urandom);
            else if (i < 16) wq.push_back(d);
            cyc(1'b0, '0, i < 16, (i % 2) == 0, 11'h7FF, d, o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL cpu_7ff cyc %0d: got %h expected %h", i, o, e);
            end
            if (o.crv) begin
                reads++;
                want = (wq.size() > 0) ? wq.pop_front() : 8'hxx;
                n_cmp++;
                if (o.crd !== want) begin
                    n_bad++;
                    $display("FAIL cpu_7ff_data cyc %0d: got %h expected %h", i, o.crd, want);
                end
            end
        end
        n_cmp++;
        if (reads != 8) begin
            n_bad++;
            $display("FAIL cpu_7ff_reads: got %0d expected 8", reads);
        end
    endtask

    task automatic test_reset_mid();
        snap_t o, e;
        logic [AW-1:0] ya;
        logic [DW-1:0] old;
        int rvs;
        ya = AW'($urandom_range(64, NMEM - 1));
        old = ref_mem[ya];
        for (int s = 0; s < 2; s++) begin
            if (s == 0) cyc(1'b1, AW'($urandom), 1'b0, 1'b0, '0, '0, o, e);
            else        cyc(1'b0, '0, 1'b1, 1'b1, ya, ~old, o, e);
            bus.vga_req = 1'b1; bus.cpu_req = 1'b1;
            #2 rst_n = 1'b0;
            @(negedge clk);
            o.vg  = bus.vga_gnt;    o.cg  = bus.cpu_gnt;
            o.vrv = bus.vga_rvalid; o.vrd = bus.vga_rdata;
            o.crv = bus.cpu_rvalid; o.crd = bus.cpu_rdata;
            o.ra  = bus.ram_addr;   o.rwe = bus.ram_we;
            n_cmp++;
            if (o !== snap_t'(0) || bus.ram_wdata !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_mid_outputs %0d: got %h wdata %h expected 0", s, o, bus.ram_wdata);
            end
            bus.vga_req = 1'b0; bus.cpu_req = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            model_reset();
            rvs = 0;
            for (int i = 0; i < 3; i++) begin
                cyc(1'b0, '0, 1'b0, 1'b0, '0, '0, o, e);
                n_cmp++;
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL reset_mid_idle %0d cyc %0d: got %h expected %h", s, i, o, e);
                end
                if (o.vrv || o.crv) rvs++;
            end
            n_cmp++;
            if (rvs != 0) begin
                n_bad++;
                $display("FAIL reset_mid_rvalid %0d: got %0d pulses expected 0", s, rvs);
            end
        end
        n_cmp++;
        if (ram_mem[ya] !== old) begin
            n_bad++;
            $display("FAIL reset_mid_ram: got %h expected %h", ram_mem[ya], old);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, '0, i == 0, 1'b0, ya, '0, o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset_mid_readback cyc %0d: got %h expected %h", i, o, e);
            end
        end
    endtask

    task automatic test_random();
        snap_t o, e;
        logic vr = 1'b0, cr = 1'b0, cw = 1'b0;
        logic [AW-1:0] va = '0, ca = '0;
        logic [DW-1:0] cd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!vr && $urandom_range(99) < 60) begin vr = 1'b1; va = AW'($urandom); end
            if (!cr && $urandom_range(99) < 50) begin
                cr = 1'b1; cw = 1'($urandom); ca = AW'($urandom_range(0, 31)); cd = DW'($urandom);
            end
            if (vr && $urandom_range(99) < 3) vr = 1'b0;
            if (cr && $urandom_range(99) < 3) cr = 1'b0;
            if (i >= 395) begin vr = 1'b0; cr = 1'b0; end
            cyc(vr, va, cr, cw, ca, cd, o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL random cyc %0d: got %h expected %h", i, o, e);
            end
            if (e.vg) vr = 1'b0;
            if (e.cg) cr = 1'b0;
        end
    endtask

    initial begin
        ram_seed = $urandom;
        for (int i = 0; i < NMEM; i++) ref_mem[i] = init_byte(i);
        bus.vga_req = 1'b0; bus.vga_addr = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        model_reset();
        test_reset();
        test_single_vga();
        test_write_read();
        test_contention();
        test_stream();
        test_cpu_7ff();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/char_ram_arbiter.md
# char_ram_arbiter

Arbitrates the single shared port of the 2048×8 character RAM between the VGA character fetcher and the CPU data bus. VGA reads have priority so that scan-out never stalls. A run-length limit guarantees the CPU a slot after a bounded number of consecutive VGA grants. The block registers the RAM command and returns tagged read data to the requester that issued it, giving a fixed two-cycle read latency.

## Interface
Parameters:
- ADDR_W, 11, character RAM address width
- DATA_W, 8, character RAM data width
- MAX_VGA_RUN, 4, consecutive VGA grants allowed while CPU is waiting (≥1)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- vga_req  in  1  VGA fetcher read request; held until granted
- vga_addr  in  ADDR_W  VGA read address; stable while vga_req=1
- vga_gnt  out  1  combinational grant to VGA this cycle
- vga_rvalid  out  1  VGA read data valid
- vga_rdata  out  DATA_W  VGA read data
- cpu_req  in  1  CPU access request; held until granted
- cpu_we  in  1  1=write, 0=read; stable while cpu_req=1
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  combinational grant to CPU this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- ram_addr  out  ADDR_W  registered RAM address
- ram_we  out  1  registered RAM write enable
- ram_wdata  out  DATA_W  registered RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_addr (synchronous read)

## Operation
- At most one grant per cycle; vga_gnt and cpu_gnt are never both 1.
- Grant rule, evaluated each cycle:
  - If only one requester asserts req, that requester is granted.
  - If both assert req: VGA wins unless run_cnt == MAX_VGA_RUN, in which case the CPU wins.
- run_cnt:
  - Width ceil(log2(MAX_VGA_RUN+1)).
  - +1 on each VGA grant while cpu_req=1.
  - Cleared on any CPU grant and in any cycle with cpu_req=0.
  - Saturates at MAX_VGA_RUN.
- On the grant edge, the granted address, we and wdata are registered onto ram_addr/ram_we/ram_wdata.
- VGA grants always set ram_we=0.
- With no grant, ram_we is 0 and ram_addr holds its previous value.
- Issue tag stage 1 (registered with the command): valid, owner (VGA/CPU), is_read.
- Tag stage 2: stage 1 delayed one cycle.
- In the stage-2 cycle, ram_rdata is registered into the owner's rdata output and that owner's rvalid pulses for one cycle.
- CPU writes produce no rvalid.
- rdata outputs hold their last value between rvalid pulses.
- Full throughput: back-to-back grants on every cycle. The pipeline never backpressures.

## Timing
- Grant in cycle k (req=1 sampled, gnt=1 combinational).
- Cycle k+1: ram_addr/ram_we valid.
- Cycle k+2: ram_rdata is captured. Outputs *_rvalid/*_rdata are valid in cycle k+2, i.e. registered at the end of k+1 from RAM output. Read latency is 2 cycles from the grant edge.
- Write: RAM is updated at the end of cycle k+1. A read granted in cycle k+1 or later to the same address returns the new data.
- Reset values (rst_n=0, asynchronous): ram_addr=0, ram_we=0, ram_wdata=0, vga_rvalid=0, cpu_rvalid=0, vga_rdata=0, cpu_rdata=0, run_cnt=0, both tag stages invalid.
- Grants are 0 while rst_n=0.
- Reset mid-transaction: in-flight reads are discarded and no rvalid is issued for them. A write registered but not yet committed is suppressed because ram_we is forced to 0.
- Requester that drops req without a grant: no access occurs and no error is raised.
- Address wrap: addresses are used modulo 2^ADDR_W with no range check.

## Test plan
- Single VGA read of addr 0x005, whose RAM location holds 0x41: vga_gnt=1 at k, ram_addr=0x005 at k+1, vga_rvalid=1 and vga_rdata=0x41 at k+2, cpu_rvalid stays 0.
- CPU write 0x5A to 0x010, then CPU read 0x010 on the next cycle: ram_we pulses once, cpu_rvalid=1 with cpu_rdata=0x5A two cycles after the read grant.
- Both requesting continuously, MAX_VGA_RUN=4: grant pattern is VGA,VGA,VGA,VGA,CPU repeating. The CPU read returns correct data and no VGA read is lost or misrouted.
- VGA streaming addresses 0..120 on consecutive cycles with no CPU: 121 consecutive grants and 121 vga_rvalid pulses in order, with no gaps.
- CPU alone issuing alternating write/read to 0x7FF: run_cnt stays 0 and each read returns the preceding write's data.
- rst_n pulled low for one cycle during k+1 of a VGA read and a CPU write: no rvalid follows, RAM location unchanged, and all outputs are at reset values while rst_n=0.
